// File: rtl/control_juego_fruta.sv
// control_juego_fruta: fruit launch, fall, catch/miss judging, score/lives/speed and game FSM.
// Ties the falling fruit to the basket x; emits the fruit paint strobe for the pixel mux.
module control_juego_fruta #(
   parameter int          FRUTA_TAM        = 16,
   parameter int          CANASTA_ANCHO    = 90,
   parameter int          CANASTA_Y        = 447,
   parameter int          VIDAS_INICIALES  = 3,
   parameter int          VEL_INICIAL      = 1,
   parameter int          VEL_MAX          = 4,
   parameter int          PUNTOS_POR_NIVEL = 10,
   parameter logic [9:0]  LFSR_SEMILLA     = 10'h1A5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic [9:0] pos_x_canasta,
   input  logic       btn_inicio,
   output logic [9:0] fruta_x,
   output logic [9:0] fruta_y,
   output logic       pintar_fruta,
   output logic [7:0] puntaje,
   output logic [1:0] vidas,
   output logic [2:0] velocidad,
   output logic       juego_activo,
   output logic       fin_juego,
   output logic       ev_atrapada,
   output logic       ev_perdida
);
   typedef enum logic [2:0] {ESPERA, LANZAR, CAYENDO, ATRAPADA, PERDIDA, FIN} estado_t;
   estado_t     estado, estado_sig;
   logic [9:0]  lfsr;
   logic [7:0]  aciertos_nivel;
   logic        btn_prev;
   logic        tick, inicio_ev, cruce, solape, fuera, atrapa;
   logic [9:0]  candidato;
   logic [10:0] y_sig, fx, fy, px, py;

   assign tick      = pixel_y == 10'd481 && pixel_x == 10'd0;
   assign inicio_ev = btn_inicio & ~btn_prev;
   assign candidato = lfsr <= 10'd624 ? lfsr : lfsr - 10'd512;
   assign fx        = {1'b0, fruta_x};
   assign fy        = {1'b0, fruta_y};
   assign px        = {1'b0, pixel_x};
   assign py        = {1'b0, pixel_y};
   assign y_sig     = fy + {8'b0, velocidad};
   assign cruce     = (fy + 11'(FRUTA_TAM) < 11'(CANASTA_Y)) && (y_sig + 11'(FRUTA_TAM) >= 11'(CANASTA_Y));
   assign solape    = (fx + 11'(FRUTA_TAM) > {1'b0, pos_x_canasta}) &&
                      (fx <= {1'b0, pos_x_canasta} + 11'(CANASTA_ANCHO));
   assign atrapa    = cruce && solape;
   assign fuera     = y_sig >= 11'd480;

   always_ff @(posedge clk) begin
      if (reset) estado <= ESPERA;
      else       estado <= estado_sig;
   end

   always_comb begin
      estado_sig = estado;
      case (estado)
         ESPERA:   estado_sig = inicio_ev ? LANZAR : ESPERA;
         LANZAR:   estado_sig = CAYENDO;
         CAYENDO:  estado_sig = !tick ? CAYENDO : atrapa ? ATRAPADA : fuera ? PERDIDA : CAYENDO;
         ATRAPADA: estado_sig = LANZAR;
         PERDIDA:  estado_sig = vidas == 2'd1 ? FIN : LANZAR;
         FIN:      estado_sig = inicio_ev ? LANZAR : FIN;
         default:  estado_sig = ESPERA;
      endcase
   end

   always_comb begin
      juego_activo = estado inside {LANZAR, CAYENDO, ATRAPADA, PERDIDA};
      fin_juego    = estado == FIN;
      ev_atrapada  = estado == ATRAPADA;
      ev_perdida   = estado == PERDIDA;
      pintar_fruta = estado == CAYENDO && px >= fx && px < fx + 11'(FRUTA_TAM) &&
                     py >= fy && py < fy + 11'(FRUTA_TAM);
   end

   // btn_prev tracks the button even in reset so a press held across reset is not a new start
   always_ff @(posedge clk) btn_prev <= btn_inicio;

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr           <= LFSR_SEMILLA;
         fruta_x        <= 10'd312;
         fruta_y        <= 10'd0;
         puntaje        <= 8'd0;
         vidas          <= 2'(VIDAS_INICIALES);
         velocidad      <= 3'(VEL_INICIAL);
         aciertos_nivel <= 8'd0;
      end else begin
         lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
         case (estado)
            LANZAR: begin
               fruta_x <= candidato;
               fruta_y <= 10'd0;
            end
            CAYENDO: if (tick && !atrapa && !fuera) fruta_y <= y_sig[9:0];
            ATRAPADA: begin
               puntaje <= puntaje == 8'hFF ? puntaje : puntaje + 8'd1;
               if (aciertos_nivel == 8'(PUNTOS_POR_NIVEL - 1)) begin
                  aciertos_nivel <= 8'd0;
                  velocidad      <= velocidad >= 3'(VEL_MAX) ? velocidad : velocidad + 3'd1;
               end else begin
                  aciertos_nivel <= aciertos_nivel + 8'd1;
               end
            end
            PERDIDA: vidas <= vidas - 2'd1;
            FIN: if (inicio_ev) begin
               puntaje        <= 8'd0;
               vidas          <= 2'(VIDAS_INICIALES);
               velocidad      <= 3'(VEL_INICIAL);
               aciertos_nivel <= 8'd0;
            end
            default: ;
         endcase
      end
   end
endmodule
